// File: rtl/tdc_stim_pkg.sv
// Purpose: shared types and constants for the TDC START/STOP stimulus generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdc_stim_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int REP_W_DEF = 8;

    localparam logic [1:0] ADDR_DELAY  = 2'd0;
    localparam logic [1:0] ADDR_WIDTH  = 2'd1;
    localparam logic [1:0] ADDR_GAP    = 2'd2;
    localparam logic [1:0] ADDR_REPEAT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/tdc_stim_cfg.sv
// Purpose: burst config registers plus a snapshot taken when a burst is accepted.
// Latency: writes visible next cycle; snapshot loads on the accept edge, live values bypass it that cycle.
// Backpressure: none; one write per cycle is always accepted.
module tdc_stim_cfg
    import tdc_stim_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int REP_W = REP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [1:0]       i_addr,
    input  logic [CNT_W-1:0] i_wdata,
    input  logic             i_snap,
    output logic [CNT_W-1:0] o_delay,
    output logic [CNT_W-1:0] o_width,
    output logic [CNT_W-1:0] o_gap,
    output logic [REP_W-1:0] o_repeat
);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_delay;
    logic [CNT_W-1:0] r_width;
    logic [CNT_W-1:0] r_gap;
    logic [REP_W-1:0] r_repeat;

    logic [CNT_W-1:0] r_snap_delay;
    logic [CNT_W-1:0] r_snap_width;
    logic [CNT_W-1:0] r_snap_gap;
    logic [REP_W-1:0] r_snap_repeat;

    // A zero width would produce no pulse at all; it is promoted to one cycle.
    logic [CNT_W-1:0] w_width_norm;
    assign w_width_norm = (r_width == '0) ? C_ONE : r_width;

    // Live register file, writable at any time including mid-burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_delay  <= '0;
            r_width  <= '0;
            r_gap    <= '0;
            r_repeat <= '0;
        end else if (i_we) begin
            case (i_addr)
                ADDR_DELAY:  r_delay  <= i_wdata;
                ADDR_WIDTH:  r_width  <= i_wdata;
                ADDR_GAP:    r_gap    <= i_wdata;
                ADDR_REPEAT: r_repeat <= REP_W'(i_wdata);
                default:     r_delay  <= r_delay;
            endcase
        end
    end

    // Freeze the burst parameters on accept; a same-cycle write lands in the next burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap_delay  <= '0;
            r_snap_width  <= '0;
            r_snap_gap    <= '0;
            r_snap_repeat <= '0;
        end else if (i_snap) begin
            r_snap_delay  <= r_delay;
            r_snap_width  <= w_width_norm;
            r_snap_gap    <= r_gap;
            r_snap_repeat <= r_repeat;
        end
    end

    // On the accept cycle the FSM needs the values the snapshot is about to hold.
    assign o_delay  = i_snap ? r_delay      : r_snap_delay;
    assign o_width  = i_snap ? w_width_norm : r_snap_width;
    assign o_gap    = i_snap ? r_gap        : r_snap_gap;
    assign o_repeat = i_snap ? r_repeat     : r_snap_repeat;

endmodule

// File: rtl/tdc_stim_gen.sv
// Purpose: emits START/STOP edge pairs DELAY cycles apart, WIDTH long, optionally repeated with GAP idle cycles.
// Latency: go sampled at edge N -> start_o high in cycle N+1, first stop_o in cycle N+1+DELAY.
// Backpressure: none; go while busy is dropped, abort always wins and idles the FSM next cycle.
module tdc_stim_gen
    import tdc_stim_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int REP_W = REP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_wdata,
    input  logic             go,
    input  logic             abort,
    output logic             start_o,
    output logic             stop_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [REP_W-1:0] pair_cnt_o
);

    localparam logic [CNT_W:0]   E_ONE = (CNT_W+1)'(1);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
    localparam logic [REP_W-1:0] P_ONE = REP_W'(1);

    state_t           r_state;
    logic [CNT_W:0]   r_e;
    logic [CNT_W-1:0] r_gap_cnt;
    logic [REP_W-1:0] r_pair;
    logic             r_start;
    logic             r_stop;
    logic             r_busy;
    logic             r_done;

    logic             w_go_acc;
    logic [CNT_W-1:0] w_delay;
    logic [CNT_W-1:0] w_width;
    logic [CNT_W-1:0] w_gap;
    logic [REP_W-1:0] w_repeat;

    logic [CNT_W:0]   w_d;
    logic [CNT_W:0]   w_w;
    logic [CNT_W:0]   w_dw;
    logic [CNT_W:0]   w_e_last;
    logic [CNT_W:0]   w_e_inc;
    logic [REP_W-1:0] w_pair_inc;
    logic             w_last_pair;
    logic             w_start_inc;
    logic             w_stop_inc;
    logic             w_stop_zero;

    assign w_go_acc = go && !abort && (r_state == ST_IDLE);

    tdc_stim_cfg #(
        .CNT_W (CNT_W),
        .REP_W (REP_W)
    ) u_cfg (
        .clk      (clk),
        .rst      (rst),
        .i_we     (cfg_we),
        .i_addr   (cfg_addr),
        .i_wdata  (cfg_wdata),
        .i_snap   (w_go_acc),
        .o_delay  (w_delay),
        .o_width  (w_width),
        .o_gap    (w_gap),
        .o_repeat (w_repeat)
    );

    // Pulse arithmetic is one bit wider than the fields so DELAY+WIDTH never wraps.
    assign w_d         = {1'b0, w_delay};
    assign w_w         = {1'b0, w_width};
    assign w_dw        = w_d + w_w;
    assign w_e_last    = w_dw - E_ONE;
    assign w_e_inc     = r_e + E_ONE;
    assign w_start_inc = (w_e_inc < w_w);
    assign w_stop_inc  = (w_e_inc >= w_d) && (w_e_inc < w_dw);
    // At e=0 start is always high (width >= 1); stop only when the edges coincide.
    assign w_stop_zero = (w_d == '0);
    assign w_pair_inc  = r_pair + P_ONE;
    assign w_last_pair = (w_repeat != '0) && (w_pair_inc == w_repeat);

    // Burst sequencer: outputs are registered for the cycle that r_e describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_e       <= '0;
            r_gap_cnt <= '0;
            r_pair    <= '0;
            r_start   <= 1'b0;
            r_stop    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state <= ST_IDLE;
                r_start <= 1'b0;
                r_stop  <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (go) begin
                            r_state <= ST_RUN;
                            r_e     <= '0;
                            r_pair  <= '0;
                            r_busy  <= 1'b1;
                            r_start <= 1'b1;
                            r_stop  <= w_stop_zero;
                        end
                    end
                    ST_RUN: begin
                        if (r_e == w_e_last) begin
                            r_pair  <= w_pair_inc;
                            r_start <= 1'b0;
                            r_stop  <= 1'b0;
                            if (w_last_pair) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else if (w_gap == '0) begin
                                r_e     <= '0;
                                r_start <= 1'b1;
                                r_stop  <= w_stop_zero;
                            end else begin
                                r_state   <= ST_GAP;
                                r_gap_cnt <= w_gap - C_ONE;
                            end
                        end else begin
                            r_e     <= w_e_inc;
                            r_start <= w_start_inc;
                            r_stop  <= w_stop_inc;
                        end
                    end
                    ST_GAP: begin
                        if (r_gap_cnt == '0) begin
                            r_state <= ST_RUN;
                            r_e     <= '0;
                            r_start <= 1'b1;
                            r_stop  <= w_stop_zero;
                        end else begin
                            r_gap_cnt <= r_gap_cnt - C_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_start <= 1'b0;
                        r_stop  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign start_o    = r_start;
    assign stop_o     = r_stop;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign pair_cnt_o = r_pair;

endmodule

// File: tb/tb_tdc_stim_gen.sv
// Purpose: bench for tdc_stim_gen; expected waveforms are generated pair-by-pair from the burst rules.
// Latency: first expected sample is the cycle after the go edge.
// Backpressure: n/a.
module tb_tdc_stim_gen;

    localparam int CNT_W = 8;
    localparam int REP_W = 8;
    localparam int EW    = REP_W + 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [CNT_W-1:0] cfg_wdata;
    logic             go;
    logic             abort;
    logic             start_o;
    logic             stop_o;
    logic             busy_o;
    logic             done_o;
    logic [REP_W-1:0] pair_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;
    int m_cfg[4];
    logic [EW-1:0] exp_q[$];

    always #5 clk = ~clk;

    tdc_stim_gen #(
        .CNT_W (CNT_W),
        .REP_W (REP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .go         (go),
        .abort      (abort),
        .start_o    (start_o),
        .stop_o     (stop_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .pair_cnt_o (pair_cnt_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] obs();
        return {start_o, stop_o, busy_o, done_o, pair_cnt_o};
    endfunction

    task automatic check_eq(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got start=%b stop=%b busy=%b done=%b pair=%0d, want start=%b stop=%b busy=%b done=%b pair=%0d",
                     tag, got[EW-1], got[EW-2], got[EW-3], got[EW-4], got[REP_W-1:0],
                     want[EW-1], want[EW-2], want[EW-3], want[EW-4], want[REP_W-1:0]);
        end
    endtask

    task automatic wr(input int a, input int d);
        cfg_we    = 1'b1;
        cfg_addr  = 2'(a);
        cfg_wdata = CNT_W'(d);
        tick();
        cfg_we    = 1'b0;
        m_cfg[a]  = d;
    endtask

    // Expected per-cycle outputs of one burst, built from the current model config.
    task automatic build_exp(input int n_cont);
        int d;
        int w;
        int g;
        int r;
        int np;
        d  = m_cfg[0];
        w  = (m_cfg[1] == 0) ? 1 : m_cfg[1];
        g  = m_cfg[2];
        r  = m_cfg[3];
        np = (r == 0) ? n_cont : r;
        exp_q.delete();
        for (int p = 0; p < np; p++) begin
            for (int e = 0; e < d + w; e++)
                exp_q.push_back({(e < w), ((e >= d) && (e < d + w)), 1'b1, 1'b0, REP_W'(p)});
            if (!(r != 0 && p == r - 1))
                for (int k = 0; k < g; k++)
                    exp_q.push_back({2'b00, 1'b1, 1'b0, REP_W'(p + 1)});
        end
        if (r != 0) begin
            exp_q.push_back({4'b0001, REP_W'(r)});
            exp_q.push_back({4'b0000, REP_W'(r)});
            exp_q.push_back({4'b0000, REP_W'(r)});
        end
    endtask

    function automatic int first_pair(input int p);
        for (int i = 0; i < exp_q.size(); i++)
            if (int'(exp_q[i][REP_W-1:0]) == p) return i;
        return -1;
    endfunction

    // Launch a burst and compare every cycle; optional mid-burst write, go, abort or reset.
    task automatic run(input string tag, input int abort_at, input int rst_at,
                       input int wr_at, input int wa, input int wd, input int go_at);
        logic [REP_W-1:0] held;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            check_eq($sformatf("%s[%0d]", tag, i), obs(), exp_q[i]);
            if (i == wr_at) begin
                cfg_we    = 1'b1;
                cfg_addr  = 2'(wa);
                cfg_wdata = CNT_W'(wd);
                m_cfg[wa] = wd;
            end
            if (i == go_at)    go    = 1'b1;
            if (i == abort_at) abort = 1'b1;
            if (i == rst_at)   rst   = 1'b1;
            held = exp_q[i][REP_W-1:0];
            tick();
            cfg_we = 1'b0;
            go     = 1'b0;
            if (i == abort_at) begin
                abort = 1'b0;
                check_eq($sformatf("%s_abort", tag), obs(), {4'b0000, held});
                tick();
                check_eq($sformatf("%s_abort_idle", tag), obs(), {4'b0000, held});
                return;
            end
            if (i == rst_at) begin
                rst = 1'b0;
                for (int a = 0; a < 4; a++) m_cfg[a] = 0;
                check_eq($sformatf("%s_rst", tag), obs(), '0);
                return;
            end
        end
    endtask

    function automatic int rnd_field(input int a);
        case (a)
            0:       return int'($urandom_range(0, 6));
            1:       return int'($urandom_range(0, 4));
            2:       return int'($urandom_range(0, 3));
            default: return int'($urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ab;
        int ga;
        int k;
        int wa;
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        go        = 1'b0;
        abort     = 1'b0;
        for (int a = 0; a < 4; a++) m_cfg[a] = 0;
        tick();
        tick();
        check_eq("reset", obs(), '0);
        rst = 1'b0;
        tick();
        check_eq("post_reset", obs(), '0);

        // Single pair, separated edges.
        wr(0, 5); wr(1, 2); wr(2, 0); wr(3, 1);
        build_exp(0);
        run("d5w2r1", -1, -1, -1, 0, 0, -1);

        // Coincident edges, two pairs with a gap.
        wr(0, 0); wr(1, 3); wr(2, 4); wr(3, 2);
        build_exp(0);
        run("d0w3g4r2", -1, -1, -1, 0, 0, -1);

        // Zero width promoted to one, back-to-back pairs.
        wr(0, 1); wr(1, 0); wr(2, 0); wr(3, 3);
        build_exp(0);
        run("d1w0g0r3", -1, -1, -1, 0, 0, -1);

        // Continuous mode aborted once ten pairs are complete.
        wr(0, 2); wr(1, 3); wr(2, 1); wr(3, 0);
        build_exp(12);
        ab = first_pair(10);
        run("cont_abort", ab, -1, -1, 0, 0, -1);

        // go and abort together: nothing starts, count holds.
        go    = 1'b1;
        abort = 1'b1;
        tick();
        go    = 1'b0;
        abort = 1'b0;
        check_eq("go_abort", obs(), {4'b0000, REP_W'(10)});
        tick();
        check_eq("go_abort_idle", obs(), {4'b0000, REP_W'(10)});

        // Mid-burst DELAY write and go while busy; next burst picks up the new DELAY.
        wr(0, 5); wr(1, 2); wr(2, 2); wr(3, 2);
        build_exp(0);
        run("midwr", -1, -1, 3, 0, 9, 8);
        build_exp(0);
        run("newdelay", -1, -1, -1, 0, 0, -1);

        // Randomised bursts with random mid-burst writes, stray go and aborts.
        for (int it = 0; it < 20; it++) begin
            for (int a = 0; a < 4; a++)
                if ($urandom_range(0, 1) == 1) wr(a, rnd_field(a));
            build_exp(4);
            ab = -1;
            if (m_cfg[3] == 0 || $urandom_range(0, 3) == 0)
                ab = int'($urandom_range(0, exp_q.size() - 1));
            k  = int'($urandom_range(0, exp_q.size() - 1));
            ga = (exp_q[k][REP_W+1] == 1'b1) ? k : -1;
            wa = int'($urandom_range(0, 3));
            run($sformatf("rnd%0d", it), ab, -1,
                int'($urandom_range(0, exp_q.size() - 1)), wa, rnd_field(wa), ga);
        end

        // Full-range fields: stop spans e=255..509.
        wr(0, 255); wr(1, 255); wr(2, 0); wr(3, 1);
        build_exp(0);
        run("d255w255", -1, -1, -1, 0, 0, -1);

        // Reset mid-RUN clears outputs and config.
        wr(3, 0);
        build_exp(1);
        run("rst_mid", -1, 300, -1, 0, 0, -1);

        // Cleared config: one-cycle coincident pairs, continuous.
        build_exp(8);
        run("zero_cfg", 5, -1, -1, 0, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
